sr_flag_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a bank of NFLAG SR flag cells among NREQ requesters.
- Each requester posts one command: a flag index plus an op (set, clear, toggle).
- The controller serialises commands, converts each into a one-cycle s/r pulse on the addressed cell, and acknowledges the requester.
- The controller never drives s=r=1 into any cell.
- Sits between control logic that owns status events and the flag register bank read by downstream logic.

---
 rtl/sr_flag_pkg.sv | 19 +
 rtl/sr_cell.sv | 34 +++
 rtl/sr_flag_arbiter.sv | 137 +++++++++++++
 tb/tb_sr_flag_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sr_flag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_flag_pkg
// Description : Op encodings and controller state encoding for sr_flag_arbiter.
// Revision    : 1.0
// ============================================================================
package sr_flag_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_TOG = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sr_cell.sv
`default_nettype none
// ============================================================================
// Module      : sr_cell
// Description : Single synchronous-reset SR flag; s=r=1 holds and is illegal.
// Revision    : 1.0
// ============================================================================
module sr_cell
    import sr_flag_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic s,
    input  logic r,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 1'b0;
        end else if (s && !r) begin
            r_q <= 1'b1;
        end else if (r && !s) begin
            r_q <= 1'b0;
        end
    end

    assign q = r_q;

    a_no_set_and_reset: assert property (@(posedge clk) disable iff (reset) !(s && r));

endmodule
`default_nettype wire

// File: rtl/sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sr_flag_arbiter
// Description : Round-robin sequencer turning requester commands into s/r
//               pulses on a bank of SR flag cells, one command per 3 cycles.
// Revision    : 1.0
// ============================================================================
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = $clog2(NFLAG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op,
    input  logic [NREQ*IDXW-1:0] idx,
    output logic [NREQ-1:0]      gnt,
    output logic                 err,
    output logic                 busy,
    output logic [NFLAG-1:0]     flags
);

    localparam int              PTRW    = $clog2(NREQ);
    localparam logic [IDXW:0]   c_nflag = (IDXW + 1)'(NFLAG);

    logic [1:0]       r_state;
    logic [PTRW-1:0]  r_rr_ptr;
    logic [PTRW-1:0]  r_win;
    logic [1:0]       r_op;
    logic [IDXW-1:0]  r_idx;
    logic [NREQ-1:0]  r_gnt;
    logic             r_err;
    logic [NFLAG-1:0] r_s;
    logic [NFLAG-1:0] r_r;

    logic             w_found;
    logic [PTRW-1:0]  w_win;
    logic             w_inrange;
    logic [NFLAG-1:0] w_s;
    logic [NFLAG-1:0] w_r;

    function automatic logic [PTRW-1:0] f_wrap(input int v);
        return PTRW'(v % NREQ);
    endfunction

    // Walk offsets from far to near so the requester closest to rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[f_wrap(int'(r_rr_ptr) + k)]) begin
                w_found = 1'b1;
                w_win   = f_wrap(int'(r_rr_ptr) + k);
            end
        end
    end

    assign w_inrange = ({1'b0, r_idx} < c_nflag);

    always_comb begin
        w_s = '0;
        w_r = '0;
        if (w_inrange) begin
            case (r_op)
                OP_SET: w_s[r_idx] = 1'b1;
                OP_CLR: w_r[r_idx] = 1'b1;
                OP_TOG: begin
                    w_s[r_idx] = ~flags[r_idx];
                    w_r[r_idx] =  flags[r_idx];
                end
                default: ;
            endcase
        end
    end

    // s/r is decoded in APPLY and registered, so the cells change on the same
    // edge that raises gnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_win    <= '0;
            r_op     <= OP_NOP;
            r_idx    <= '0;
            r_gnt    <= '0;
            r_err    <= 1'b0;
            r_s      <= '0;
            r_r      <= '0;
        end else begin
            r_gnt <= '0;
            r_err <= 1'b0;
            r_s   <= '0;
            r_r   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_win   <= w_win;
                        r_op    <= op[2*w_win +: 2];
                        r_idx   <= idx[w_win*IDXW +: IDXW];
                        r_state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_s     <= w_s;
                    r_r     <= w_r;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_gnt[r_win] <= 1'b1;
                    r_err        <= ~w_inrange;
                    r_rr_ptr     <= f_wrap(int'(r_win) + 1);
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NFLAG; g++) begin : g_cell
        sr_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .s     (r_s[g]),
            .r     (r_r[g]),
            .q     (flags[g])
        );
    end

    assign gnt  = r_gnt;
    assign err  = r_err;
    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_flag_arbiter
// Description : Lock-step check of an 8-flag and a 6-flag arbiter against a
//               transaction-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_sr_flag_arbiter;

    localparam int NREQ = 4;
    localparam int IDXW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req;
    logic [7:0]      op;
    logic [11:0]     idx;
    logic [3:0]      gnt8, gnt6;
    logic            err8, err6, busy8, busy6;
    logic [7:0]      flags8;
    logic [5:0]      flags6;

    int total = 0;
    int bad   = 0;

    // Model state: one pending command per instance, aged in cycles since latch.
    int         nf[2] = '{8, 6};
    logic [7:0] m_flags[2];
    int         m_rr[2];
    bit         p_valid[2];
    int         p_age[2], p_win[2], p_op[2], p_idx[2];
    logic [3:0] e_gnt[2];
    bit         e_err[2];

    always #5 clk = ~clk;

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(8)) u_dut8 (
        .clk(clk), .reset(reset), .req(req), .op(op), .idx(idx),
        .gnt(gnt8), .err(err8), .busy(busy8), .flags(flags8)
    );

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(6)) u_dut6 (
        .clk(clk), .reset(reset), .req(req), .op(op), .idx(idx),
        .gnt(gnt6), .err(err6), .busy(busy6), .flags(flags6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            e_gnt[i] = 4'd0;
            e_err[i] = 1'b0;
            if (reset) begin
                m_flags[i] = 8'd0;
                m_rr[i]    = 0;
                p_valid[i] = 1'b0;
            end else if (p_valid[i]) begin
                p_age[i]++;
                if (p_age[i] == 2) begin
                    if (p_idx[i] < nf[i]) begin
                        case (p_op[i])
                            1: m_flags[i][p_idx[i]] = 1'b1;
                            2: m_flags[i][p_idx[i]] = 1'b0;
                            3: m_flags[i][p_idx[i]] = ~m_flags[i][p_idx[i]];
                            default: ;
                        endcase
                    end
                    e_gnt[i]   = 4'(1 << p_win[i]);
                    e_err[i]   = (p_idx[i] >= nf[i]);
                    m_rr[i]    = (p_win[i] + 1) % NREQ;
                    p_valid[i] = 1'b0;
                end
            end else if (req != 4'd0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (m_rr[i] + k) % NREQ;
                    if (!p_valid[i] && req[c]) begin
                        p_valid[i] = 1'b1;
                        p_age[i]   = 0;
                        p_win[i]   = c;
                        p_op[i]    = int'(op[2*c +: 2]);
                        p_idx[i]   = int'(idx[c*IDXW +: IDXW]);
                    end
                end
            end
        end
    endtask

    // One clock: update the model at the edge, compare at the falling edge,
    // and let granted requesters withdraw before the next edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("flags8", 32'(flags8), 32'(m_flags[0]));
        check("gnt8",   32'(gnt8),   32'(e_gnt[0]));
        check("err8",   32'(err8),   32'(e_err[0]));
        check("busy8",  32'(busy8),  32'(p_valid[0]));
        check("flags6", 32'(flags6), 32'(m_flags[1][5:0]));
        check("gnt6",   32'(gnt6),   32'(e_gnt[1]));
        check("err6",   32'(err6),   32'(e_err[1]));
        check("busy6",  32'(busy6),  32'(p_valid[1]));
        for (int k = 0; k < NREQ; k++)
            if (e_gnt[0][k]) req[k] = 1'b0;
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) cycle();
    endtask

    task automatic post(input int k, input logic [1:0] o, input int ix);
        req[k]           = 1'b1;
        op[2*k +: 2]     = o;
        idx[k*IDXW +: IDXW] = 3'(ix);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        op    = 8'h00;
        idx   = 12'h000;
        @(negedge clk);

        // Reset held with all requesters active, then NOPs drain in order.
        run(2);
        reset = 1'b0;
        run(13);

        // Single SET from requester 2.
        post(2, 2'b01, 5);
        run(6);
        check("single_set", 32'(flags8), 32'h20);

        // Rotation from rr_ptr=0.
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        for (int k = 0; k < NREQ; k++) post(k, 2'b01, k);
        run(14);
        check("rotation_flags", 32'(flags8), 32'h0F);

        // Move rr_ptr to 2 with a NOP from requester 1, then rotate again.
        post(1, 2'b00, 0);
        run(4);
        for (int k = 0; k < NREQ; k++) post(k, 2'b01, k);
        run(14);

        // Toggle / clear sequence.
        post(1, 2'b11, 0);
        run(4);
        post(1, 2'b11, 4);
        run(4);
        post(1, 2'b10, 1);
        run(4);
        check("tog_clr_flags", 32'(flags8), 32'h1C);

        // Index 7: in range for 8 flags, out of range for 6.
        post(3, 2'b01, 7);
        run(4);

        // Reset while a command is in APPLY.
        post(0, 2'b01, 6);
        run(1);
        reset = 1'b1;
        run(1);
        check("abort_flags", 32'(flags8), 32'h00);
        reset = 1'b0;
        post(1, 2'b01, 3);
        run(8);

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < NREQ; k++)
                if (!req[k] && ($urandom_range(0, 2) == 0))
                    post(k, 2'($urandom), int'($urandom_range(0, 7)));
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;
        req   = 4'b0000;
        run(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
